axis_sample_source: RTL and testbench
=====================================

Name: axis_sample_source

Overview:
- Paced AXI-Stream master that plays a stored sample buffer into the m_axis-style input of the IIR biquad (s_axis_tdata/s_axis_tvalid).
- Samples are preloaded through a simple write port and emitted one per sample period (CLKS_PER_SAMPLE clocks, e.g. 5 clocks = 10 MS/s at 50 MHz).
- Honours downstream tready. Flags overrun when the sink stalls past a sample tick.

Parameters:
- DATA_WIDTH, 16: sample width (signed two's complement).
- ADDR_WIDTH, 10: buffer address width; DEPTH = 2**ADDR_WIDTH.
- CLKS_PER_SAMPLE, 5: clocks per sample period. Must be >= 3.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_WIDTH  buffer write address.
- wr_data  in  DATA_WIDTH  buffer write data.
- num_samples  in  ADDR_WIDTH+1  samples per pass, 1..DEPTH; sampled at start.
- loop_en  in  1  1 = wrap to index 0 after the last sample; sampled at start.
- start  in  1  begin playback; honoured only in IDLE.
- stop  in  1  abort playback.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at the end of a non-loop pass.
- overrun  out  1  sticky; cleared on accepted start.
- m_axis_tdata  out  DATA_WIDTH  sample.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; busy, done, overrun, m_axis_tvalid = 0; m_axis_tdata = 0; index and tick counter = 0. Buffer contents are not reset.
- Reset mid-playback aborts immediately with no done pulse.
- Buffer: synchronous, read-first. A read and a write to the same address in the same cycle returns the old data. Writes are allowed in any state.
- FSM states: IDLE, FETCH, SEND, WAIT_TICK, DONE.
- IDLE:
  - start=1 and num_samples != 0 → FETCH. Latch num_samples and loop_en, set index=0, clear overrun, tick counter=0.
  - start=1 with num_samples == 0 → ignored.
- Tick counter: free-runs 0..CLKS_PER_SAMPLE-1 while busy. Tick = (counter == CLKS_PER_SAMPLE-1).
- FETCH (1 cycle): issue a buffer read at index → SEND.
- SEND:
  - Entry cycle: m_axis_tvalid=1 and m_axis_tdata = buffer[index].
  - tvalid and tdata are held stable until tvalid & tready.
  - On handshake: tvalid=0 next cycle.
    - Last index (num_samples-1) with loop_en=0 → DONE.
    - Last index with loop_en=1 → index=0, WAIT_TICK.
    - Otherwise → index+1, WAIT_TICK.
- WAIT_TICK: on tick → FETCH.
- Overrun: a tick that occurs in FETCH or SEND sets overrun. That tick is dropped, not queued; the next sample waits for the following tick.
- DONE: done=1 for one cycle → IDLE.
- Timing (tready held high, start accepted at cycle 0):
  - Sample k has tvalid high exactly in cycle 2 + k*CLKS_PER_SAMPLE.
  - Latency from start to first sample is 2 cycles.
- m_axis_tdata keeps the last sent value while tvalid=0.
- stop:
  - In FETCH or WAIT_TICK → IDLE next cycle.
  - In SEND → IDLE after the pending handshake completes; tvalid never drops without a handshake.
  - stop never produces a done pulse.
  - stop and start in the same IDLE cycle: start wins.
- start while busy: ignored.

Test Plan:
- Load buffer[0..3] = 100, -200, 300, -400; num_samples=4, loop_en=0, tready=1, start at cycle 0 → tvalid in cycles 2, 7, 12, 17 with tdata 100, -200, 300, -400; done pulse at cycle 19; busy low from cycle 20; overrun=0.
- Same setup with tready=0 during cycles 7..14 → sample -200 held with tvalid=1 through cycle 15; overrun=1; 300 appears at cycle 22 (next tick after 15 is cycle 20, so FETCH at 21, tvalid at 22).
- num_samples=2, loop_en=1 → tdata sequence 100, -200, 100, -200, ... every 5 cycles with no done pulse. Assert stop while in WAIT_TICK → busy=0 next cycle, no done pulse.
- Assert rst_n=0 asynchronously mid-SEND → tvalid, busy, tdata drop to 0 immediately. After release, restart replays from buffer[0] with its preloaded value intact.
- Write buffer[0]=777 in the same cycle as the FETCH of index 0 → old value emitted. num_samples=0 with start → busy stays 0.
- Load 1000 samples from a sine+noise file into the filter-under-test path → output stream matches the golden model in order and count.

Source files
------------

// File: rtl/axis_sample_source.sv
// Paced AXI-Stream sample player: replays a preloaded buffer, one sample per
// CLKS_PER_SAMPLE clocks, honouring tready and flagging dropped sample ticks.
module axis_sample_source #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 10,
    parameter int CLKS_PER_SAMPLE = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH:0]   num_samples,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLKS_PER_SAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_TICK,
        DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   index;
    logic [ADDR_WIDTH-1:0]   last_idx;
    logic                    loop_lat;
    logic                    stop_pend;
    logic [CNT_W-1:0]        tick_cnt;
    logic                    tick;
    logic [ADDR_WIDTH:0]     num_m1;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign tick   = busy && (tick_cnt == TICK_LAST);
    assign num_m1 = num_samples - 1'b1;

    // Sample buffer: plain write port; the read happens inside the FSM flop
    // below, so a same-cycle write to the fetched address returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            last_idx      <= '0;
            loop_lat      <= 1'b0;
            stop_pend     <= 1'b0;
            tick_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (busy) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            end

            // A tick that lands while a sample is still in flight is lost.
            if (tick && (state == FETCH || state == SEND)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && (num_samples != '0)) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        last_idx  <= num_m1[ADDR_WIDTH-1:0];
                        loop_lat  <= loop_en;
                        index     <= '0;
                        overrun   <= 1'b0;
                        tick_cnt  <= '0;
                        stop_pend <= 1'b0;
                    end
                end

                FETCH: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        m_axis_tdata  <= mem[index];
                        m_axis_tvalid <= 1'b1;
                        state         <= SEND;
                    end
                end

                SEND: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        if (stop || stop_pend) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else if (index == last_idx) begin
                            if (loop_lat) begin
                                index <= '0;
                                state <= WAIT_TICK;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            index <= index + 1'b1;
                            state <= WAIT_TICK;
                        end
                    end
                end

                WAIT_TICK: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        state <= FETCH;
                    end
                end

                // Two cycles here: the first arms done, the second shows it with busy
                // still high, so busy falls on the cycle after the pulse.
                DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    m_axis_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_sample_source.sv
// Self-checking bench for axis_sample_source: directed scenarios plus randomized
// passes, compared cycle by cycle against an event-level timing model.
module tb_axis_sample_source;

    localparam int DW   = 16;
    localparam int AW   = 10;
    localparam int P    = 5;
    localparam int MAXC = 400;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [AW:0]          num_samples;
    logic                 loop_en;
    logic                 start;
    logic                 stop;
    logic                 busy;
    logic                 done;
    logic                 overrun;
    logic signed [DW-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;

    axis_sample_source #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CLKS_PER_SAMPLE(P)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .num_samples(num_samples),
        .loop_en(loop_en),
        .start(start),
        .stop(stop),
        .busy(busy),
        .done(done),
        .overrun(overrun),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [DW-1:0] model_mem [0:(1<<AW)-1];
    logic signed [DW-1:0] last_data;

    bit                   rdy   [0:MAXC];
    bit                   ev    [0:MAXC];
    bit                   eb    [0:MAXC];
    bit                   ed    [0:MAXC];
    logic signed [DW-1:0] es    [0:MAXC];
    bit                   exp_ovr;
    int                   exp_done_c;
    int                   done_seen;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic load(input int addr, input logic signed [DW-1:0] val);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = val;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_mem[addr] = val;
    endtask

    // Cycle 0 = start presented; cycle c's counter is (c-1)%P, so ticks fall on c%P==0.
    task automatic build_model(input int n, input bit loop, input int ncyc, input int stop_cyc);
        int send, h, k, limit, bend;
        bit fin;
        logic signed [DW-1:0] hold;
        for (int c = 0; c <= MAXC; c++) begin
            ev[c] = 0; eb[c] = 0; ed[c] = 0; es[c] = '0;
        end
        limit = (stop_cyc > 0) ? stop_cyc : ncyc;
        send = 2; k = 0; fin = 0; exp_ovr = 0; exp_done_c = -1;
        while (!fin && send <= limit) begin
            h = send;
            while (h < ncyc && !rdy[h]) h++;
            for (int c = send; c <= h; c++) begin
                ev[c] = 1;
                es[c] = model_mem[k % n];
            end
            for (int c = send - 1; c <= h; c++) if (c % P == 0) exp_ovr = 1;
            if (!loop && k == n - 1) begin
                exp_done_c = h + 2;
                fin = 1;
            end else begin
                send = (h / P + 1) * P + 2;
                k++;
            end
        end
        bend = (exp_done_c >= 0) ? exp_done_c : limit;
        for (int c = 1; c <= bend && c <= ncyc; c++) eb[c] = 1;
        if (exp_done_c >= 0 && exp_done_c <= ncyc) ed[exp_done_c] = 1;
        hold = last_data;
        for (int c = 0; c <= ncyc; c++) begin
            if (ev[c]) hold = es[c];
            else es[c] = hold;
        end
    endtask

    // Entered and left at #1 after a rising edge; the entry cycle is cycle 0.
    task automatic run_pass(input int n, input bit loop, input int ncyc, input int stop_cyc,
                            input int wr_cyc, input logic signed [DW-1:0] wr_val,
                            input bit noise, input bit stop_with_start);
        build_model(n, loop, ncyc, stop_cyc);
        done_seen     = -1;
        num_samples   = (AW+1)'(n);
        loop_en       = loop;
        start         = 1'b1;
        stop          = stop_with_start;
        m_axis_tready = rdy[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            m_axis_tready = rdy[c];
            start = noise && eb[c] && ($urandom_range(0, 1) == 1);
            stop  = (c == stop_cyc);
            if (c == wr_cyc) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = wr_val;
            end
            @(negedge clk);
            chk($sformatf("tvalid@%0d", c), m_axis_tvalid, ev[c]);
            chk($sformatf("tdata@%0d", c), m_axis_tdata, es[c]);
            chk($sformatf("busy@%0d", c), busy, eb[c]);
            chk($sformatf("done@%0d", c), done, ed[c]);
            if (done && done_seen < 0) done_seen = c;
            @(posedge clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
        end
        chk("overrun", overrun, exp_ovr);
        last_data = es[ncyc];
        if (wr_cyc > 0) model_mem[0] = wr_val;
    endtask

    task automatic fill_rdy(input int lo, input int hi, input bit val);
        for (int c = lo; c <= hi; c++) rdy[c] = val;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        num_samples = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        m_axis_tready = 1'b1;
        last_data = '0;
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load(0, 16'sd100);
        load(1, -16'sd200);
        load(2, 16'sd300);
        load(3, -16'sd400);

        // Straight pass with a permanently ready sink.
        fill_rdy(0, MAXC, 1);
        run_pass(4, 0, 22, 0, 0, '0, 0, 0);
        chk("plain_done_cycle", done_seen, 19);

        // Sink stalls across two ticks: sample held, ticks dropped.
        fill_rdy(0, MAXC, 1);
        fill_rdy(7, 14, 0);
        run_pass(4, 0, 32, 0, 0, '0, 0, 0);
        chk("stall_overrun", overrun, 1);
        chk("stall_done_cycle", done_seen, 29);

        // Looping pass stopped in WAIT_TICK; start+stop together at cycle 0.
        fill_rdy(0, MAXC, 1);
        run_pass(2, 1, 24, 23, 0, '0, 0, 1);
        chk("loop_no_done", done_seen, -1);

        // Async reset while a sample is waiting for tready.
        fill_rdy(0, MAXC, 0);
        run_pass(4, 0, 2, 0, 0, '0, 0, 0);
        chk("pre_rst_tvalid", m_axis_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", m_axis_tvalid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_tdata", m_axis_tdata, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_data = '0;
        fill_rdy(0, MAXC, 1);
        run_pass(4, 0, 22, 0, 0, '0, 0, 0);

        // Write to buffer[0] during its FETCH returns old data; next pass sees new.
        run_pass(1, 0, 6, 0, 1, 16'sd777, 0, 0);
        run_pass(1, 0, 6, 0, 0, '0, 0, 0);

        // Zero-length start is ignored.
        num_samples = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("zero_len_busy@%0d", c), busy, 0);
            chk($sformatf("zero_len_tvalid@%0d", c), m_axis_tvalid, 0);
            @(posedge clk);
            #1;
        end

        // Randomized passes with a flaky sink and spurious starts while busy.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) load(i, DW'($urandom));
            for (int c = 0; c <= MAXC; c++) rdy[c] = ($urandom_range(0, 99) < 65) || (c >= 100);
            run_pass(n, 0, 200, 0, 0, '0, 1, 0);
            chk($sformatf("rand%0d_done_cycle", r), done_seen, exp_done_c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
